// File: rtl/vgascope_capture_ctrl.sv
// Capture sequencer for the VGA scope push path: prescaled sampling, trigger,
// fixed-length burst into a small FIFO, and a gapped valid/ready drain.
module vgascope_capture_ctrl #(
  parameter int DEPTH = 8,
  parameter int DW    = 6,
  parameter int DIV_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_enable,
  input  logic [DIV_W-1:0]       cfg_div,
  input  logic [1:0]             cfg_trig_mode,
  input  logic [DW-1:0]          cfg_trig_level,
  input  logic [6:0]             cfg_count,
  input  logic [DW-1:0]          sample_in,
  input  logic                   arm,
  input  logic                   frame_start,
  input  logic                   push_ready,
  output logic                   push_valid,
  output logic [DW-1:0]          push_data,
  output logic [1:0]             state,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow,
  input  logic                   overflow_clr,
  output logic                   burst_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_CAPTURE = 3'd2,
    S_HOLD    = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [DW-1:0]    prev_q, prev_d;
  logic [6:0]       cnt_q, cnt_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             gap_q, gap_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic [DW-1:0]    mem_q [DEPTH];

  logic       tick;
  logic       rise;
  logic       fall;
  logic       fire;
  logic [6:0] burst_len;
  logic [6:0] cnt_inc;
  logic       wr_req;
  logic       full;
  logic       wr_en;
  logic       drop;
  logic       pop;

  // A live cfg_div lowered below the running count still ticks at once
  // instead of waiting for the counter to wrap through 2^DIV_W.
  assign tick      = (state_q != S_IDLE) && (presc_q >= cfg_div);
  assign burst_len = (cfg_count == 7'd0) ? 7'd64 : cfg_count;
  assign cnt_inc   = cnt_q + 7'd1;
  assign rise      = (prev_q < cfg_trig_level) && (sample_in >= cfg_trig_level);
  assign fall      = (prev_q >= cfg_trig_level) && (sample_in < cfg_trig_level);

  always_comb begin
    case (cfg_trig_mode)
      2'b00:   fire = 1'b1;
      2'b10:   fire = fall;
      default: fire = rise;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prev_d  = prev_q;
    wr_req  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_ARMED;
      S_ARMED: begin
        if (tick) begin
          prev_d = sample_in;
          if (fire) begin
            wr_req = 1'b1;
            cnt_d  = 7'd1;
            if (7'd1 >= burst_len) begin
              done_d  = 1'b1;
              state_d = S_HOLD;
            end else begin
              state_d = S_CAPTURE;
            end
          end
        end
      end
      S_CAPTURE: begin
        if (tick) begin
          prev_d = sample_in;
          wr_req = 1'b1;
          cnt_d  = cnt_inc;
          if (cnt_inc >= burst_len) begin
            done_d  = 1'b1;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (frame_start) state_d = (cfg_trig_mode == 2'b11) ? S_DONE : S_ARMED;
      end
      S_DONE: begin
        if (arm) state_d = S_ARMED;
      end
      default: state_d = S_IDLE;
    endcase
    if (!cfg_enable) begin
      state_d = S_IDLE;
      cnt_d   = 7'd0;
      prev_d  = prev_q;
      wr_req  = 1'b0;
      done_d  = 1'b0;
    end
  end

  // Full is judged on the registered level, so a same-cycle pop never frees room.
  assign full       = (level_q == LW'(DEPTH));
  assign wr_en      = wr_req && !full;
  assign drop       = wr_req && full;
  assign push_valid = (level_q != '0) && !gap_q;
  assign pop        = push_valid && push_ready;

  always_comb begin
    presc_d  = (state_q == S_IDLE || tick) ? '0 : presc_q + 1'b1;
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    gap_d    = pop;
    level_d  = level_q;
    if (wr_en && !pop)      level_d = level_q + 1'b1;
    else if (!wr_en && pop) level_d = level_q - 1'b1;
    ovf_d = ovf_q;
    if (overflow_clr) ovf_d = 1'b0;
    if (drop)         ovf_d = 1'b1;
    if (!cfg_enable) begin
      presc_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      gap_d    = 1'b0;
      level_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      prev_q   <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      gap_q    <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      gap_q    <= gap_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= sample_in;
  end

  // Empty FIFO presents zero so the output is defined before the first write.
  assign push_data  = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign fifo_level = level_q;
  assign overflow   = ovf_q;
  assign burst_done = done_q;

  always_comb begin
    case (state_q)
      S_ARMED:           state = 2'b01;
      S_CAPTURE, S_HOLD: state = 2'b10;
      S_DONE:            state = 2'b11;
      default:           state = 2'b00;
    endcase
  end

endmodule

// File: doc/vgascope_capture_ctrl.md
Name: vgascope_capture_ctrl

Overview:
- Capture sequencer that feeds the VGA scope peripheral's push-value path.
- Samples a 6-bit input at a programmable rate and waits for a configurable trigger.
- Records a fixed-length burst into a small FIFO, then drains the FIFO to the scope through a valid/ready handshake. Drain happens only while the scope signals ready, i.e. outside the active video rows.
- Sits between the peripheral register bank / ui_in and the scope shift-register push logic.

Parameters:
- DEPTH, 8: FIFO entries; power of two, minimum 2.
- DW, 6: sample and push data width.
- DIV_W, 16: prescaler width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- cfg_enable  in  1  run enable; 0 forces IDLE and flushes the FIFO.
- cfg_div  in  DIV_W  sample tick period minus 1.
- cfg_trig_mode  in  2  trigger mode: 00 free-run, 01 rising, 10 falling, 11 single-shot rising.
- cfg_trig_level  in  DW  trigger threshold.
- cfg_count  in  7  samples per burst, 1..64; 0 means 64.
- sample_in  in  DW  sampled value, already synchronised.
- arm  in  1  pulse; re-arms from DONE.
- frame_start  in  1  one-cycle pulse at the start of each frame.
- push_ready  in  1  scope can accept a value.
- push_valid  out  1  push_data is valid.
- push_data  out  DW  FIFO head.
- state  out  2  current state: 00 IDLE, 01 ARMED, 10 CAPTURE/HOLD, 11 DONE.
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky: a sample was dropped.
- overflow_clr  in  1  clears overflow.
- burst_done  out  1  one-cycle pulse when the last sample of a burst is taken.

Behaviour:
- Reset: state IDLE, FIFO empty, push_valid=0, push_data=0, fifo_level=0, overflow=0, burst_done=0, prescaler=0, prev_sample=0, sample counter=0.
- Prescaler:
  - Counts 0..cfg_div; tick is asserted on the cycle count==cfg_div, then the count wraps to 0. Tick period is cfg_div+1 cycles; cfg_div=0 gives a tick every cycle.
  - Held at 0 while the state is IDLE.
- Internal states: IDLE, ARMED, CAPTURE, HOLD, DONE. CAPTURE and HOLD both report state=10.
- IDLE:
  - Moves to ARMED the cycle after cfg_enable=1.
  - cfg_enable=0 in any state: next state is IDLE, FIFO pointers cleared, push_valid=0 next cycle, burst in progress discarded. overflow is retained.
- ARMED, on each tick:
  - Trigger test: mode 00 always fires; 01/11 fire when prev_sample<level and sample_in>=level; 10 fires when prev_sample>=level and sample_in<level.
  - On fire: go to CAPTURE; the triggering sample is written as burst sample #1.
  - prev_sample<=sample_in on every tick in ARMED and in CAPTURE.
- CAPTURE:
  - Each tick writes sample_in to the FIFO and increments the sample counter.
  - When the counter reaches N (cfg_count, 0→64): burst_done pulses that cycle and the state goes to HOLD. If N=1, the trigger tick itself completes the burst.
- HOLD:
  - Waits for frame_start; this caps the rate at one burst per frame.
  - On frame_start: mode 11 goes to DONE, other modes go to ARMED.
  - Ticks in HOLD write nothing.
- DONE: waits for an arm pulse, then goes to ARMED. prev_sample is not reset.
- FIFO write and overflow:
  - A write is refused if the FIFO is full at the start of the cycle, even if a pop occurs in the same cycle.
  - A refused sample is dropped, overflow is set, and the sample counter still advances.
  - overflow_clr clears overflow; a simultaneous set wins.
- Push handshake:
  - push_valid = FIFO non-empty and gap=0.
  - push_data = FIFO head; stable while push_valid=1 and not accepted.
  - Transfer = push_valid && push_ready. It pops the head and sets gap for exactly one cycle, so push_valid is low the cycle after every transfer. Maximum drain rate is 1 per 2 cycles; the scope latches one value per write strobe.
  - Write and pop in the same cycle: fifo_level unchanged.
- fifo_level is registered and exact, range 0..DEPTH.
- Pointers wrap modulo DEPTH.
- Config inputs are sampled live; changing them mid-burst is legal, and the new cfg_count takes effect on the next comparison.

Test Plan:
- Reset, enable, mode 00, div=3, count=4, push_ready=0, sample_in ramps 0,1,2,… one step per tick:
  - Samples land 4 cycles apart; fifo_level reaches 4; burst_done pulses once.
  - After frame_start: state returns to ARMED.
- Mode 01, level=20, sample_in steps 10→19→20:
  - Trigger fires on the 20 tick.
  - First pushed value is 20; no capture before it.
- FIFO drain: 4 entries, push_ready=1 constant:
  - push_valid pattern 1,0,1,0,1,0,1.
  - Data popped in order.
  - fifo_level reaches 0 after the 4th transfer.
- Overflow: DEPTH=8, count=10, div=0, push_ready=0:
  - 8 entries stored.
  - overflow=1 after the 9th sample.
  - burst_done still pulses on the 10th sample.
  - overflow_clr with a simultaneous drop leaves overflow=1.
- Single-shot: mode 11, count=2:
  - After the burst and frame_start, state=11 and no further captures.
  - After an arm pulse, state=01.
- Abort: cfg_enable dropped mid-CAPTURE with 3 entries queued:
  - Next cycle: state=00, fifo_level=0, push_valid=0.
  - overflow unchanged.
